// File: rtl/riscv_lsu.sv
// -----------------------------------------------------------------------------
// riscv_lsu -- load/store unit, initiator side of the riscv_mem port.
//
// Accepts one load or store per handshake, computes ea = base + offset,
// pulses the memory strobe for exactly one cycle, waits READ_LAT cycles for
// load data, and returns size-masked, sign/zero-extended data plus a fault
// flag for illegal funct3 (and, optionally, misaligned accesses).
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned half/word accesses fault
//                         undefined -> misaligned accesses go to memory as-is
//
// Parameters:
//   READ_LAT    cycles from mem_RE sampled to mem_rdata valid (1..4)
//
// Ports:
//   clk, reset                      rising-edge clock, async active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_funct3              store flag, RV32 funct3
//   req_base, req_offset, req_wdata rs1, sign-extended imm, rs2
//   resp_valid/resp_ready           response handshake
//   resp_rdata, resp_fault          extended load data (0 for stores/faults)
//   mem_addr, mem_wdata, mem_rdata  memory address / write data / read data
//   mem_WE, mem_RE, mem_by          one-cycle strobes, access size
//   dbg_state                       current FSM state (0 IDLE, 1 ISSUE,
//                                   2 WAIT, 3 RESP)
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both high; valid never depends on ready, and the
// payload is stable while valid is high and ready is low.
// -----------------------------------------------------------------------------
module riscv_lsu #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_WE,
  output logic        mem_RE,
  output logic [1:0]  mem_by,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // WAIT counts down from READ_LAT-1 to 0; the capture happens on the edge
  // that sees 0, so WAIT lasts exactly READ_LAT cycles.
  localparam logic [1:0] LP_WAIT_INIT = 2'(READ_LAT - 1);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_fault;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [1:0]  r_mem_by;
  logic        r_mem_we;
  logic        r_mem_re;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_cnt;

  logic [31:0] w_ea;
  logic [1:0]  w_size;
  logic        w_illegal;
  logic        w_fault;
  logic [31:0] w_wdata_masked;
  logic [31:0] w_load_ext;

  // Request decode (only meaningful while IDLE).
  always_comb begin
    w_ea   = req_base + req_offset;
    w_size = req_funct3[1:0];
    if (req_we) begin
      // Stores: only SB/SH/SW (0..2) are legal.
      w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'd3);
    end else begin
      // Loads: 3 and 7 share [1:0]==3; 6 is the only other hole.
      w_illegal = (req_funct3[1:0] == 2'd3) | (req_funct3 == 3'd6);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    w_fault = w_illegal
            | ((w_size == 2'd1) & w_ea[0])
            | ((w_size == 2'd2) & (w_ea[1:0] != 2'd0));
`else
    w_fault = w_illegal;
`endif
    // riscv_mem takes low-aligned data, so no lane shifting here.
    case (w_size)
      2'd0:    w_wdata_masked = {24'd0, req_wdata[7:0]};
      2'd1:    w_wdata_masked = {16'd0, req_wdata[15:0]};
      default: w_wdata_masked = req_wdata;
    endcase
  end

  // Load data extension, selected by the funct3 latched at accept.
  always_comb begin
    case (r_funct3)
      3'd0:    w_load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    w_load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    w_load_ext = {24'd0, mem_rdata[7:0]};
      3'd5:    w_load_ext = {16'd0, mem_rdata[15:0]};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_by     <= '0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_mem_addr   <= w_ea;
            r_mem_by     <= w_size;
            r_mem_wdata  <= w_wdata_masked;
            r_we         <= req_we;
            r_funct3     <= req_funct3;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b0;
            if (w_fault) begin
              // Faults skip memory entirely and respond on the next cycle.
              r_resp_fault <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_resp_fault <= 1'b0;
              r_mem_re     <= ~req_we;
              r_mem_we     <= req_we;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_mem_re <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_we) begin
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt   <= LP_WAIT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_resp_rdata <= w_load_ext;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_by     = r_mem_by;
  assign mem_WE     = r_mem_we;
  assign mem_RE     = r_mem_re;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst3;

  // ---------------- DUT (READ_LAT = 1) ----------------
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_WE, mem_RE;
  logic [1:0]  mem_by, dbg_state;

  riscv_lsu #(.READ_LAT(LAT)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_WE(mem_WE), .mem_RE(mem_RE), .mem_by(mem_by), .dbg_state(dbg_state)
  );

  // ---------------- DUT (READ_LAT = 3), reset-in-flight tests ----------------
  logic        req_valid3, req_ready3, req_we3;
  logic [2:0]  req_funct3_3;
  logic [31:0] req_base3, req_offset3, req_wdata3;
  logic        resp_valid3, resp_ready3, resp_fault3;
  logic [31:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        mem_WE3, mem_RE3;
  logic [1:0]  mem_by3, dbg_state3;

  riscv_lsu #(.READ_LAT(LAT3)) dut3 (
    .clk(clk), .reset(rst3),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_funct3(req_funct3_3), .req_base(req_base3), .req_offset(req_offset3),
    .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_rdata(resp_rdata3), .resp_fault(resp_fault3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .mem_WE(mem_WE3), .mem_RE(mem_RE3), .mem_by(mem_by3), .dbg_state(dbg_state3)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory contents ----------------
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return 8'(a * 32'd37 + 32'd11);
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  logic [7:0] ref_mem[logic [31:0]];   // reference model's view
  logic [7:0] phys_mem[logic [31:0]];  // what the DUT actually wrote

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] v, b;
    for (int i = 0; i < 4; i++) begin
      b = a + 32'(i);
      v[8*i +: 8] = ref_mem.exists(b) ? ref_mem[b] : init_byte(b);
    end
    return v;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    logic [31:0] v, b;
    for (int i = 0; i < 4; i++) begin
      b = a + 32'(i);
      v[8*i +: 8] = phys_mem.exists(b) ? phys_mem[b] : init_byte(b);
    end
    return v;
  endfunction

  function automatic logic [31:0] init_rd(input logic [31:0] a);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = init_byte(a + 32'(i));
    return v;
  endfunction

  // ---------------- memory responders ----------------
  // Read data is only valid during the single cycle before the capture edge;
  // every other cycle carries random garbage.
  int          rd_age = 0, rd_age3 = 0;
  logic [31:0] rd_word = '0, rd_word3 = '0;

  always @(posedge clk) begin
    if (mem_WE)
      for (int i = 0; i < nbytes(mem_by); i++)
        phys_mem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
    if (mem_RE) begin
      rd_age  = 1;
      rd_word = phys_rd(mem_addr);
    end else if (rd_age > 0) begin
      rd_age = (rd_age >= LAT) ? 0 : rd_age + 1;
    end
    mem_rdata <= (rd_age == LAT) ? rd_word : $urandom;
  end

  always @(posedge clk) begin
    if (mem_RE3) begin
      rd_age3  = 1;
      rd_word3 = init_rd(mem_addr3);
    end else if (rd_age3 > 0) begin
      rd_age3 = (rd_age3 >= LAT3) ? 0 : rd_age3 + 1;
    end
    mem_rdata3 <= (rd_age3 == LAT3) ? rd_word3 : $urandom;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic        fault;
    logic [31:0] ea;
    logic [31:0] wdm;
    logic [31:0] rdata;
    logic [1:0]  size;
    int          resp_k;   // edges after accept until resp_valid is visible
  } txn_t;

  function automatic txn_t predict(input logic we, input logic [2:0] f3,
                                   input logic [31:0] base, off, wd);
    txn_t t;
    logic illegal;
    logic [31:0] raw;
    t.we   = we;
    t.ea   = base + off;
    t.size = f3[1:0];
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
    t.fault = illegal || (t.size == 2'd1 && t.ea[0]) || (t.size == 2'd2 && t.ea[1:0] != 2'd0);
`else
    t.fault = illegal;
`endif
    t.wdm = (t.size == 2'd0) ? {24'd0, wd[7:0]} : (t.size == 2'd1) ? {16'd0, wd[15:0]} : wd;
    t.rdata = '0;
    if (!t.fault && we)
      for (int i = 0; i < nbytes(t.size); i++) ref_mem[t.ea + 32'(i)] = t.wdm[8*i +: 8];
    if (!t.fault && !we) begin
      raw = ref_rd(t.ea);
      case (f3)
        3'd0:    t.rdata = {{24{raw[7]}}, raw[7:0]};
        3'd1:    t.rdata = {{16{raw[15]}}, raw[15:0]};
        3'd4:    t.rdata = {24'd0, raw[7:0]};
        3'd5:    t.rdata = {16'd0, raw[15:0]};
        default: t.rdata = raw;
      endcase
    end
    t.resp_k = t.fault ? 0 : (we ? 1 : 1 + LAT);
    return t;
  endfunction

  txn_t        cur;
  logic        busy = 1'b0;
  int          k = 0;
  logic [31:0] exp_q[$];
  int          re_pulses = 0, we_pulses = 0;

  // Model advance: accept / take decisions on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0;
      k    = 0;
    end else if (busy) begin
      if (k >= cur.resp_k && resp_ready) begin
        busy = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        k++;
      end
    end else if (req_valid) begin
      cur  = predict(req_we, req_funct3, req_base, req_offset, req_wdata);
      busy = 1'b1;
      k    = 0;
      exp_q.push_back(cur.rdata);
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_RE) re_pulses++;
      if (mem_WE) we_pulses++;
      chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      chk("mem_RE", {31'd0, mem_RE}, {31'd0, busy && k == 0 && !cur.fault && !cur.we});
      chk("mem_WE", {31'd0, mem_WE}, {31'd0, busy && k == 0 && !cur.fault && cur.we});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, busy && k >= cur.resp_k});
      if (busy) begin
        chk("mem_addr", mem_addr, cur.ea);
        chk("mem_by", {30'd0, mem_by}, {30'd0, cur.size});
        if (cur.size != 2'd3) chk("mem_wdata", mem_wdata, cur.wdm);
        if (k >= cur.resp_k) begin
          chk("resp_fault", {31'd0, resp_fault}, {31'd0, cur.fault});
          if (exp_q.size() > 0) chk("resp_rdata", resp_rdata, exp_q[0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] base, off, wd, input int hold,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output logic [31:0] iss_addr, iss_wdata, output logic [1:0] iss_by);
    int n;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_base = $urandom; req_offset = $urandom;
    req_wdata = $urandom; req_funct3 = 3'($urandom);
    iss_addr = mem_addr; iss_wdata = mem_wdata; iss_by = mem_by;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    if (!resp_valid) begin
      checks++; failures++;
      $display("FAIL resp_timeout: got no resp_valid within %0d cycles", n);
    end
    rd = resp_rdata; flt = resp_fault;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd, ia, iw;
    logic        flt;
    logic [1:0]  ib;
    int          lat, re0, we0, n, rv_seen;

    rst = 1'b1; rst3 = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_base = '0;
    req_offset = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid3 = 1'b0; req_we3 = 1'b0; req_funct3_3 = '0; req_base3 = '0;
    req_offset3 = '0; req_wdata3 = '0; resp_ready3 = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; rst3 = 1'b0;

    // Reset state
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_RE", {31'd0, mem_RE}, 32'd0);
    chk("rst_mem_WE", {31'd0, mem_WE}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // SW then LW at 0x104
    re0 = re_pulses; we0 = we_pulses;
    do_req(1'b1, 3'd2, 32'h100, 32'd4, 32'hDEADBEEF, 0, rd, flt, lat, ia, iw, ib);
    chk("sw_lat", lat, 32'd1);
    chk("sw_fault", {31'd0, flt}, 32'd0);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_addr", ia, 32'h104);
    chk("sw_we_pulses", we_pulses - we0, 32'd1);
    chk("sw_re_pulses", re_pulses - re0, 32'd0);
    re0 = re_pulses;
    do_req(1'b0, 3'd2, 32'h100, 32'd4, 32'h0, 0, rd, flt, lat, ia, iw, ib);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_lat", lat, 32'd2);
    chk("lw_re_pulses", re_pulses - re0, 32'd1);

    // SB / LB / LBU / SH / LH at 0x20 (LBU via negative offset)
    do_req(1'b1, 3'd0, 32'h20, 32'd0, 32'h123456F0, 0, rd, flt, lat, ia, iw, ib);
    chk("sb_wdata", iw, 32'h000000F0);
    chk("sb_by", {30'd0, ib}, 32'd0);
    do_req(1'b0, 3'd0, 32'h20, 32'd0, 32'h0, 0, rd, flt, lat, ia, iw, ib);
    chk("lb_rdata", rd, 32'hFFFFFFF0);
    do_req(1'b0, 3'd4, 32'h30, 32'hFFFFFFF0, 32'h0, 0, rd, flt, lat, ia, iw, ib);
    chk("lbu_rdata", rd, 32'h000000F0);
    chk("lbu_addr", ia, 32'h20);
    do_req(1'b1, 3'd1, 32'h20, 32'd0, 32'hAAAA80F0, 0, rd, flt, lat, ia, iw, ib);
    chk("sh_wdata", iw, 32'h000080F0);
    chk("sh_by", {30'd0, ib}, 32'd1);
    do_req(1'b0, 3'd1, 32'h20, 32'd0, 32'h0, 0, rd, flt, lat, ia, iw, ib);
    chk("lh_rdata", rd, 32'hFFFF80F0);

    // Misaligned LW at 0x102
    re0 = re_pulses;
    do_req(1'b0, 3'd2, 32'h100, 32'd2, 32'h0, 0, rd, flt, lat, ia, iw, ib);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_fault", {31'd0, flt}, 32'd1);
    chk("mis_lat", lat, 32'd0);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_re_pulses", re_pulses - re0, 32'd0);
`else
    chk("mis_fault", {31'd0, flt}, 32'd0);
    chk("mis_addr", ia, 32'h102);
    chk("mis_lat", lat, 32'd2);
    chk("mis_re_pulses", re_pulses - re0, 32'd1);
`endif

    // Illegal funct3: load 3, store 3
    re0 = re_pulses; we0 = we_pulses;
    do_req(1'b0, 3'd3, 32'h100, 32'd0, 32'h0, 0, rd, flt, lat, ia, iw, ib);
    chk("ill_ld_fault", {31'd0, flt}, 32'd1);
    chk("ill_ld_rdata", rd, 32'd0);
    chk("ill_ld_lat", lat, 32'd0);
    do_req(1'b1, 3'd3, 32'h100, 32'd0, 32'h55, 0, rd, flt, lat, ia, iw, ib);
    chk("ill_st_fault", {31'd0, flt}, 32'd1);
    chk("ill_strobes", (re_pulses - re0) + (we_pulses - we0), 32'd0);

    // Response held off for 3 cycles
    do_req(1'b0, 3'd2, 32'h100, 32'd4, 32'h0, 3, rd, flt, lat, ia, iw, ib);
    chk("hold_lw_rdata", rd, 32'hDEADBEEF);
    chk("after_take_ready", {31'd0, req_ready}, 32'd1);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] base, off;
      int          sel;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)   f3 = 3'($urandom_range(0, 7));
      else if (we)    f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      base = 32'h100 + 32'($urandom_range(0, 63));
      off  = 32'($urandom_range(0, 16)) - 32'd8;
      do_req(we, f3, base, off, $urandom, $urandom_range(0, 3), rd, flt, lat, ia, iw, ib);
    end

    // READ_LAT = 3: reset during WAIT
    req_valid3 = 1'b1; req_we3 = 1'b0; req_funct3_3 = 3'd2;
    req_base3 = 32'h40; req_offset3 = 32'd0; req_wdata3 = 32'd0; resp_ready3 = 1'b1;
    @(posedge clk); #1; req_valid3 = 1'b0;
    chk("l3_issue_RE", {31'd0, mem_RE3}, 32'd1);
    @(posedge clk); #1;
    chk("l3_wait_state", {30'd0, dbg_state3}, 32'd2);
    rst3 = 1'b1; #1;
    chk("l3_rst_RE", {31'd0, mem_RE3}, 32'd0);
    chk("l3_rst_WE", {31'd0, mem_WE3}, 32'd0);
    chk("l3_rst_valid", {31'd0, resp_valid3}, 32'd0);
    chk("l3_rst_ready", {31'd0, req_ready3}, 32'd1);
    chk("l3_rst_state", {30'd0, dbg_state3}, 32'd0);
    @(posedge clk); #1; rst3 = 1'b0;
    rv_seen = 0;
    repeat (6) begin @(posedge clk); #1; if (resp_valid3) rv_seen++; end
    chk("l3_no_resp", rv_seen, 32'd0);
    chk("l3_ready_after", {31'd0, req_ready3}, 32'd1);

    // READ_LAT = 3: reset during ISSUE drops the strobe at once
    req_valid3 = 1'b1;
    @(posedge clk); #1; req_valid3 = 1'b0;
    rst3 = 1'b1; #1;
    chk("l3_issue_rst_RE", {31'd0, mem_RE3}, 32'd0);
    @(posedge clk); #1; rst3 = 1'b0;

    // READ_LAT = 3: normal LW afterwards
    resp_ready3 = 1'b0;
    req_valid3 = 1'b1;
    @(posedge clk); #1; req_valid3 = 1'b0;
    chk("l3_lw_addr", mem_addr3, 32'h40);
    chk("l3_lw_by", {30'd0, mem_by3}, 32'd2);
    chk("l3_lw_wdata", mem_wdata3, 32'd0);
    chk("l3_lw_WE", {31'd0, mem_WE3}, 32'd0);
    n = 0;
    while (!resp_valid3 && n < 20) begin @(posedge clk); #1; n++; end
    chk("l3_lw_lat", n, 32'd4);
    chk("l3_lw_rdata", resp_rdata3, init_rd(32'h40));
    chk("l3_lw_fault", {31'd0, resp_fault3}, 32'd0);
    resp_ready3 = 1'b1;
    @(posedge clk); #1; resp_ready3 = 1'b0;
    chk("l3_lw_ready", {31'd0, req_ready3}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
